regfile_write_arbiter: RTL and testbench

Shares the single register-file write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg) between the processor writeback stage and N_SIDE side requesters, such as the game-input unit and the tick timer. Processor writeback has absolute priority and is never back-pressured. Each side requester has a one-deep holding slot, a valid/ready handshake and round-robin arbitration. A starvation guard raises cpu_stall so that side writes always complete eventually.

---
 rtl/regfile_write_arbiter.sv | 138 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between processor writeback (absolute priority)
// and N_SIDE side requesters, each holding a one-deep slot served round-robin with a starvation guard.
module regfile_write_arbiter #(
   parameter int N_SIDE       = 2,
   parameter int STARVE_LIMIT = 16
) (
   input  logic                  clock,
   input  logic                  ctrl_reset,
   input  logic                  wb_en,
   input  logic [4:0]            wb_reg,
   input  logic [31:0]           wb_data,
   input  logic [N_SIDE-1:0]     side_valid,
   input  logic [5*N_SIDE-1:0]   side_reg,
   input  logic [32*N_SIDE-1:0]  side_data,
   output logic [N_SIDE-1:0]     side_ready,
   output logic                  ctrl_writeEnable,
   output logic [4:0]            ctrl_writeReg,
   output logic [31:0]           data_writeReg,
   output logic                  cpu_stall,
   output logic [3:0]            grant_id
);

   localparam int PW = (N_SIDE > 1) ? $clog2(N_SIDE) : 1;

   logic [N_SIDE-1:0]        slot_full;
   logic [N_SIDE-1:0][4:0]   slot_reg;
   logic [N_SIDE-1:0][31:0]  slot_data;
   logic [N_SIDE-1:0]        starved;
   logic [N_SIDE-1:0]        gnt_vec;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] gnt_idx;
   logic          side_any;
   logic          side_win;

   logic          we_q;
   logic [4:0]    wreg_q;
   logic [31:0]   wdata_q;
   logic          stall_q;
   logic [3:0]    gid_q;

   for (genvar gi = 0; gi < N_SIDE; gi++) begin : g_slot
      logic        full_q;
      logic [4:0]  reg_q;
      logic [31:0] data_q;
      logic [7:0]  wait_q;

      always_ff @(posedge clock) begin
         if (ctrl_reset) begin
            full_q <= 1'b0;
            reg_q  <= '0;
            data_q <= '0;
            wait_q <= '0;
         end else begin
            // a slot being granted stays unavailable until the following cycle
            if (gnt_vec[gi]) begin
               full_q <= 1'b0;
            end else if (!full_q && side_valid[gi]) begin
               full_q <= 1'b1;
               reg_q  <= side_reg[5*gi +: 5];
               data_q <= side_data[32*gi +: 32];
            end
            if (!full_q || gnt_vec[gi]) begin
               wait_q <= '0;
            end else if (wait_q != 8'hFF) begin
               wait_q <= wait_q + 8'd1;
            end
         end
      end

      assign slot_full[gi]  = full_q;
      assign slot_reg[gi]   = reg_q;
      assign slot_data[gi]  = data_q;
      assign starved[gi]    = (wait_q >= 8'(STARVE_LIMIT));
      assign side_ready[gi] = ~full_q;
   end

   // Scan from the highest offset down so the nearest filled slot at/after ptr_q wins.
   always_comb begin
      int          j;
      logic [PW-1:0] jj;
      side_any = 1'b0;
      gnt_idx  = '0;
      j        = 0;
      jj       = '0;
      for (int k = N_SIDE - 1; k >= 0; k--) begin
         j = int'(ptr_q) + k;
         if (j >= N_SIDE) j = j - N_SIDE;
         jj = PW'(j);
         if (slot_full[jj]) begin
            side_any = 1'b1;
            gnt_idx  = jj;
         end
      end
   end

   always_comb begin
      side_win = side_any & ~wb_en;
      gnt_vec  = side_win ? (N_SIDE'(1) << gnt_idx) : '0;
      if (int'(gnt_idx) == N_SIDE - 1) ptr_d = '0;
      else                             ptr_d = gnt_idx + PW'(1);
   end

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         we_q    <= 1'b0;
         wreg_q  <= '0;
         wdata_q <= '0;
         gid_q   <= '0;
         stall_q <= 1'b0;
         ptr_q   <= '0;
      end else begin
         stall_q <= |starved;
         if (wb_en) begin
            we_q    <= 1'b1;
            wreg_q  <= wb_reg;
            wdata_q <= wb_data;
            gid_q   <= 4'd0;
         end else if (side_win) begin
            // register 0 is never written from a side slot, but the grant still completes
            we_q    <= (slot_reg[gnt_idx] != 5'd0);
            wreg_q  <= slot_reg[gnt_idx];
            wdata_q <= slot_data[gnt_idx];
            gid_q   <= 4'(gnt_idx) + 4'd1;
            ptr_q   <= ptr_d;
         end else begin
            we_q <= 1'b0;
         end
      end
   end

   assign ctrl_writeEnable = we_q;
   assign ctrl_writeReg    = wreg_q;
   assign data_writeReg    = wdata_q;
   assign cpu_stall        = stall_q;
   assign grant_id         = gid_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic, all checked
// against a slot/age-based reference model.
module tb_regfile_write_arbiter;

   localparam int N     = 2;
   localparam int LIMIT = 16;

   logic          clock = 1'b0;
   logic          ctrl_reset;
   logic          wb_en;
   logic [4:0]    wb_reg;
   logic [31:0]   wb_data;
   logic [N-1:0]  side_valid;
   logic [5*N-1:0]  side_reg;
   logic [32*N-1:0] side_data;
   logic [N-1:0]  side_ready;
   logic          ctrl_writeEnable;
   logic [4:0]    ctrl_writeReg;
   logic [31:0]   data_writeReg;
   logic          cpu_stall;
   logic [3:0]    grant_id;

   regfile_write_arbiter #(.N_SIDE(N), .STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .ctrl_reset(ctrl_reset),
      .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
      .side_valid(side_valid), .side_reg(side_reg), .side_data(side_data),
      .side_ready(side_ready),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .data_writeReg(data_writeReg), .cpu_stall(cpu_stall), .grant_id(grant_id)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: which slots hold a request, their contents, and the cycle they filled
   bit            m_init = 0;
   int unsigned   m_cyc  = 0;
   bit            m_full [N];
   logic [4:0]    m_reg  [N];
   logic [31:0]   m_data [N];
   int unsigned   m_since[N];
   int            m_ptr;
   logic          e_we, e_stall;
   logic [4:0]    e_reg;
   logic [31:0]   e_data;
   logic [3:0]    e_gid;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_next(input logic rst, input logic wb, input logic [4:0] wr,
                             input logic [31:0] wd, input logic [N-1:0] sv,
                             input logic [5*N-1:0] sr, input logic [32*N-1:0] sd);
      int g;
      bit st;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_full[i] = 0; m_reg[i] = '0; m_data[i] = '0; m_since[i] = 0;
         end
         m_ptr = 0; e_we = 0; e_reg = '0; e_data = '0; e_gid = '0; e_stall = 0;
         m_init = 1;
      end else begin
         // a request that has been waiting LIMIT cycles or more this cycle stalls the CPU next cycle
         st = 0;
         for (int i = 0; i < N; i++)
            if (m_full[i] && (m_cyc - m_since[i]) >= LIMIT) st = 1;
         g = -1;
         if (wb) begin
            e_we = 1; e_reg = wr; e_data = wd; e_gid = 4'd0;
         end else begin
            for (int k = 0; k < N; k++)
               if (g < 0 && m_full[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g >= 0) begin
               e_we   = (m_reg[g] != 5'd0);
               e_reg  = m_reg[g];
               e_data = m_data[g];
               e_gid  = 4'(g + 1);
               m_ptr  = (g + 1) % N;
            end else begin
               e_we = 0;
            end
         end
         for (int i = 0; i < N; i++) begin
            if (i == g) m_full[i] = 0;
            else if (!m_full[i] && sv[i]) begin
               m_full[i]  = 1;
               m_reg[i]   = sr[5*i +: 5];
               m_data[i]  = sd[32*i +: 32];
               m_since[i] = m_cyc + 1;
            end
         end
         e_stall = st;
      end
      m_cyc++;
   endtask

   task automatic cycle(input logic rst, input logic wb, input logic [4:0] wr,
                        input logic [31:0] wd, input logic [N-1:0] sv,
                        input logic [5*N-1:0] sr, input logic [32*N-1:0] sd);
      logic [N-1:0] exp_rdy;
      ctrl_reset = rst; wb_en = wb; wb_reg = wr; wb_data = wd;
      side_valid = sv; side_reg = sr; side_data = sd;
      #1;
      if (m_init) begin
         for (int i = 0; i < N; i++) exp_rdy[i] = ~m_full[i];
         chk("side_ready", side_ready, exp_rdy);
      end
      model_next(rst, wb, wr, wd, sv, sr, sd);
      @(posedge clock);
      #1;
      chk("writeEnable", ctrl_writeEnable, e_we);
      chk("writeReg", ctrl_writeReg, e_reg);
      chk("writeData", data_writeReg, e_data);
      chk("grant_id", grant_id, e_gid);
      chk("cpu_stall", cpu_stall, e_stall);
      if (ctrl_writeEnable === 1'b1)
         $display("txn cyc=%0d src=%0d r%0d <= %08h stall=%0b", m_cyc, grant_id,
                  ctrl_writeReg, data_writeReg, cpu_stall);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 5'd0, 32'd0, '0, '0, '0);
   endtask

   initial begin : main
      int n;
      logic [N-1:0]    rsv;
      logic [5*N-1:0]  rsr;
      logic [32*N-1:0] rsd;

      // reset held two cycles with both requesters active: nothing may be captured
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 2'b11, {5'd3, 5'd4}, {32'h22, 32'h33});
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 2'b11, {5'd3, 5'd4}, {32'h22, 32'h33});
      chk("rst_ready", side_ready, 2'b11);
      chk("rst_we", ctrl_writeEnable, 1'b0);
      chk("rst_stall", cpu_stall, 1'b0);
      idle();
      chk("rst_no_capture_we", ctrl_writeEnable, 1'b0);

      // processor priority over a filled slot
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 2'b01, {5'd0, 5'd7}, {32'd0, 32'h11});
      cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 2'b00, '0, '0);
      chk("prio_reg", ctrl_writeReg, 5'd5);
      chk("prio_data", data_writeReg, 32'hDEADBEEF);
      chk("prio_gid", grant_id, 4'd0);
      idle();
      chk("prio_slot_reg", ctrl_writeReg, 5'd7);
      chk("prio_slot_gid", grant_id, 4'd1);

      // round robin with both slots refilled whenever ready
      for (int i = 0; i < 10; i++)
         cycle(1'b0, 1'b0, 5'd0, 32'd0, 2'b11, {5'd12, 5'd11}, {32'hB0 + i, 32'hA0 + i});
      idle(); idle(); idle();

      // starvation: slot1 waits behind continuous processor writes
      cycle(1'b0, 1'b1, 5'd1, 32'h1, 2'b10, {5'd9, 5'd0}, {32'hA5A5A5A5, 32'd0});
      n = 0;
      while (cpu_stall !== 1'b1 && n < 40) begin
         cycle(1'b0, 1'b1, 5'd2, 32'h100 + n, 2'b00, '0, '0);
         n++;
      end
      chk("starve_rise_cycles", n, 17);
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 2'b00, '0, '0);
      chk("starve_reg", ctrl_writeReg, 5'd9);
      chk("starve_data", data_writeReg, 32'hA5A5A5A5);
      chk("starve_stall_hold", cpu_stall, 1'b1);
      idle();
      chk("starve_stall_fall", cpu_stall, 1'b0);

      // register-zero request is consumed without a write; pointer moves past it
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 2'b01, {5'd0, 5'd0}, {32'd0, 32'hFFFFFFFF});
      idle();
      chk("r0_we", ctrl_writeEnable, 1'b0);
      chk("r0_gid", grant_id, 4'd1);
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 2'b11, {5'd14, 5'd13}, {32'h2, 32'h1});
      idle();
      chk("r0_ptr_next_gid", grant_id, 4'd2);
      idle(); idle();

      // reset with both slots full discards them
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 2'b11, {5'd20, 5'd21}, {32'h5, 32'h6});
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 2'b00, '0, '0);
      chk("midrst_we", ctrl_writeEnable, 1'b0);
      idle();
      chk("midrst_we2", ctrl_writeEnable, 1'b0);
      chk("midrst_ready", side_ready, 2'b11);

      // random traffic
      for (int t = 0; t < 1500; t++) begin
         rsv = 2'($urandom_range(0, 3));
         rsr = 10'($urandom);
         rsd = {32'($urandom), 32'($urandom)};
         cycle(1'b0 | ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
               5'($urandom), 32'($urandom), rsv, rsr, rsd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
